// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter feeding two one-byte requesters into a single UART transmitter with watchdog abort
module tx_arbiter #(
  parameter int NB_DATA    = 8,
  parameter int NB_TIMEOUT = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_req0_valid,
  input  logic [NB_DATA-1:0] i_req0_data,
  output logic               o_req0_ready,
  input  logic               i_req1_valid,
  input  logic [NB_DATA-1:0] i_req1_data,
  output logic               o_req1_ready,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_tx_done,
  output logic [1:0]         o_grant,
  output logic               o_busy,
  output logic               o_timeout_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;
  localparam logic [NB_TIMEOUT-1:0] WD_LAST = {{(NB_TIMEOUT-1){1'b1}}, 1'b0};
  state_t              state;
  logic                full0, full1, last_grant;
  logic [NB_DATA-1:0]  data0, data1;
  logic [NB_TIMEOUT-1:0] wd;
  logic                wd_hit, frame_end, pick1;
  assign o_req0_ready = !full0;
  assign o_req1_ready = !full1;
  // Frame ends on done or on the last watchdog cycle; winner alternates when both buffers hold data.
  always_comb begin
    wd_hit    = wd == WD_LAST;
    frame_end = state == WAIT && (i_tx_done || wd_hit);
    pick1     = full1 && (!full0 || !last_grant);
  end
  // One-entry buffers: fill when empty, drain only when the owning frame ends.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      if (i_req0_valid && !full0) begin
        full0 <= 1'b1;
        data0 <= i_req0_data;
      end else if (frame_end && o_grant[0]) full0 <= 1'b0;
      if (i_req1_valid && !full1) begin
        full1 <= 1'b1;
        data1 <= i_req1_data;
      end else if (frame_end && o_grant[1]) full1 <= 1'b0;
    end
  end
  // Transmit sequencer: launch a frame, then wait for done or the watchdog.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      o_tx_start    <= 1'b0;
      o_tx_data     <= '0;
      o_grant       <= 2'b00;
      o_busy        <= 1'b0;
      o_timeout_err <= 1'b0;
      wd            <= '0;
      last_grant    <= 1'b1;
    end else begin
      case (state)
        IDLE: if (full0 || full1) begin
          state      <= START;
          o_tx_start <= 1'b1;
          o_tx_data  <= pick1 ? data1 : data0;
          o_grant    <= pick1 ? 2'b10 : 2'b01;
          o_busy     <= 1'b1;
        end
        START: begin
          state      <= WAIT;
          o_tx_start <= 1'b0;
          wd         <= '0;
        end
        WAIT: if (frame_end) begin
          state      <= IDLE;
          o_grant    <= 2'b00;
          o_busy     <= 1'b0;
          last_grant <= o_grant[1];
          if (!i_tx_done) o_timeout_err <= 1'b1;
        end else wd <= wd + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed self-checking bench for tx_arbiter
module tb_tx_arbiter;
  logic       clk = 1'b0, rst = 1'b1, v0 = 1'b0, v1 = 1'b0, done = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       ready0, ready1, tx_start, busy, err;
  logic [7:0] tx_data;
  logic [1:0] grant;
  int         checks = 0, failures = 0, cyc = 0, n0 = 0, s0 = 0;
  int         q_cyc[$];
  logic [7:0] q_data[$];
  logic [1:0] q_grant[$];
  tx_arbiter #(.NB_DATA(8), .NB_TIMEOUT(4)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(ready0),
    .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(ready1),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .i_tx_done(done),
    .o_grant(grant), .o_busy(busy), .o_timeout_err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_start === 1'b1) begin
    q_cyc.push_back(cyc);
    q_data.push_back(tx_data);
    q_grant.push_back(grant);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task automatic produce(input bit which, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      int   t = 0;
      logic r;
      if (which) begin v1 = 1'b1; d1 = base + 8'(i); end
      else begin v0 = 1'b1; d0 = base + 8'(i); end
      do begin
        r = which ? ready1 : ready0;
        tick;
        t++;
      end while (!r && t < 200);
      check(which ? "prod1_accept" : "prod0_accept", 32'(r), 1);
    end
    if (which) v1 = 1'b0; else v0 = 1'b0;
  endtask
  task automatic respond(input int frames);
    for (int f = 0; f < frames; f++) begin
      int t = 0;
      while (tx_start !== 1'b1 && t < 100) begin tick; t++; end
      check("resp_start_seen", 32'(tx_start), 1);
      repeat (2) tick;
      done = 1'b1;
      tick;
      done = 1'b0;
    end
  endtask
  initial begin
    do_reset;
    check("rst_ready0", 32'(ready0), 1);
    check("rst_ready1", 32'(ready1), 1);
    check("rst_start", 32'(tx_start), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    // single frame from req0, done 10 cycles after start
    n0 = q_data.size();
    v0 = 1'b1; d0 = 8'hA5;
    tick;
    v0 = 1'b0;
    check("s_ready0_full", 32'(ready0), 0);
    check("s_idle_busy", 32'(busy), 0);
    tick;
    check("s_start", 32'(tx_start), 1);
    check("s_data", 32'(tx_data), 32'hA5);
    check("s_grant", 32'(grant), 1);
    check("s_busy", 32'(busy), 1);
    for (int i = 1; i <= 10; i++) begin
      tick;
      check("s_wait_ready0", 32'(ready0), 0);
      check("s_wait_start", 32'(tx_start), 0);
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    check("s_end_ready0", 32'(ready0), 1);
    check("s_end_grant", 32'(grant), 0);
    check("s_end_busy", 32'(busy), 0);
    check("s_end_data", 32'(tx_data), 32'hA5);
    check("s_frames", 32'(q_data.size() - n0), 1);
    // tie after reset: req0 first, then req1, minimum spacing
    do_reset;
    n0 = q_data.size();
    v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22;
    tick;
    v0 = 1'b0; v1 = 1'b0;
    tick;
    check("t_start0", 32'(tx_start), 1);
    check("t_data0", 32'(tx_data), 32'h11);
    check("t_grant0", 32'(grant), 1);
    check("t_ready1_held", 32'(ready1), 0);
    tick;
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t_idle_grant", 32'(grant), 0);
    check("t_idle_busy", 32'(busy), 0);
    tick;
    check("t_start1", 32'(tx_start), 1);
    check("t_data1", 32'(tx_data), 32'h22);
    check("t_grant1", 32'(grant), 2);
    tick;
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t_frames", 32'(q_data.size() - n0), 2);
    if (q_cyc.size() >= n0 + 2) check("t_spacing_ge3", 32'(q_cyc[n0+1] - q_cyc[n0] >= 3), 1);
    // fairness: both stream 4 bytes continuously
    do_reset;
    n0 = q_data.size();
    fork
      produce(1'b0, 8'h40, 4);
      produce(1'b1, 8'h80, 4);
      respond(8);
    join
    check("f_frames", 32'(q_data.size() - n0), 8);
    for (int i = 0; i < 8; i++) if (n0 + i < q_data.size()) begin
      check("f_data", 32'(q_data[n0+i]), (i % 2 == 0) ? 32'h40 + 32'(i / 2) : 32'h80 + 32'(i / 2));
      check("f_grant", 32'(q_grant[n0+i]), (i % 2 == 0) ? 1 : 2);
    end
    // done coincident with the watchdog limit counts as done
    v0 = 1'b1; d0 = 8'h77;
    tick;
    v0 = 1'b0;
    tick;
    check("l_start", 32'(tx_start), 1);
    repeat (15) tick;
    check("l_still_busy", 32'(busy), 1);
    done = 1'b1;
    tick;
    done = 1'b0;
    check("l_no_err", 32'(err), 0);
    check("l_idle", 32'(busy), 0);
    check("l_ready0", 32'(ready0), 1);
    // watchdog abort with no done
    v1 = 1'b1; d1 = 8'h3C;
    tick;
    v1 = 1'b0;
    tick;
    check("w_start", 32'(tx_start), 1);
    check("w_data", 32'(tx_data), 32'h3C);
    check("w_grant", 32'(grant), 2);
    repeat (15) tick;
    check("w_pre_err", 32'(err), 0);
    check("w_pre_busy", 32'(busy), 1);
    check("w_pre_ready1", 32'(ready1), 0);
    tick;
    check("w_err", 32'(err), 1);
    check("w_busy", 32'(busy), 0);
    check("w_grant_idle", 32'(grant), 0);
    check("w_ready1", 32'(ready1), 1);
    repeat (3) tick;
    check("w_err_sticky", 32'(err), 1);
    // reset mid-frame with req1 also full, coincident done
    do_reset;
    v0 = 1'b1; d0 = 8'h55;
    tick;
    v0 = 1'b0;
    tick;
    check("r_start", 32'(tx_start), 1);
    v1 = 1'b1; d1 = 8'h66;
    tick;
    v1 = 1'b0;
    tick;
    check("r_ready1_full", 32'(ready1), 0);
    check("r_busy", 32'(busy), 1);
    rst = 1'b1; done = 1'b1;
    tick;
    rst = 1'b0; done = 1'b0;
    check("r_ready0", 32'(ready0), 1);
    check("r_ready1", 32'(ready1), 1);
    check("r_busy0", 32'(busy), 0);
    check("r_grant", 32'(grant), 0);
    check("r_data", 32'(tx_data), 0);
    check("r_err", 32'(err), 0);
    s0 = q_data.size();
    done = 1'b1;
    tick;
    done = 1'b0;
    repeat (4) tick;
    check("r_late_done_busy", 32'(busy), 0);
    check("r_late_done_grant", 32'(grant), 0);
    check("r_no_frames", 32'(q_data.size() - s0), 0);
    // spurious done while idle and empty
    done = 1'b1;
    tick;
    done = 1'b0;
    tick;
    check("sp_busy", 32'(busy), 0);
    check("sp_grant", 32'(grant), 0);
    check("sp_ready0", 32'(ready0), 1);
    check("sp_ready1", 32'(ready1), 1);
    check("sp_err", 32'(err), 0);
    check("sp_no_frames", 32'(q_data.size() - s0), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
